instr_load_encoder: RTL and testbench

Sequential instruction encoder and program loader: the inverse of the main control decoder. It accepts field-level instruction descriptions (class, registers, funct, immediate) over a valid/ready handshake, packs them into 32-bit RV32I words for the five supported opcodes (R-type, I-type ALU, load, store, branch), and writes them one per transaction into instruction memory at consecutive word addresses. It sits on the test/boot side of the processor, feeding the instruction memory write port.

---
 rtl/instr_load_encoder_pkg.sv | 36 +++
 rtl/instr_load_encoder_if.sv | 41 ++++
 rtl/instr_load_encoder_pack.sv | 37 +++
 rtl/instr_load_encoder.sv | 106 ++++++++++
 tb/tb_instr_load_encoder.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_load_encoder_pkg.sv
// Shared opcode, class and state definitions for the instruction loader.
// Also used by the main control decoder bench to keep encodings in sync.
package instr_load_encoder_pkg;

    localparam int DEF_ADDR_WIDTH = 8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_IALU   = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [12:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/instr_load_encoder_if.sv
// Loader bus: session control, field-bundle handshake, imem write port, status.
// slave = encoder side, master = producer / memory / observer side.
interface instr_load_encoder_if
    import instr_load_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_class;
    logic                  in_last;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [12:0]           in_imm;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH:0]   count;

    modport slave (
        input  start, start_addr, in_valid, in_class, in_last,
        input  in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output busy, done, err, count
    );

    modport master (
        output start, start_addr, in_valid, in_class, in_last,
        output in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  busy, done, err, count
    );
endinterface

// File: rtl/instr_load_encoder_pack.sv
// rv_instr_pack: combinational field bundle -> RV32I word plus legal flag.
// Ports: fields_i (class + fields), word_o (encoded), legal_o (class 0..4).
module rv_instr_pack
    import instr_load_encoder_pkg::*;
(
    input  instr_fields_t fields_i,
    output logic [31:0]   word_o,
    output logic          legal_o
);
    logic [12:0] imm;
    assign imm = fields_i.imm;

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        unique case (1'b1)
            (fields_i.cls == CLS_R):
                word_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                          fields_i.funct3, fields_i.rd, OP_R};
            (fields_i.cls == CLS_IALU):
                word_o = {imm[11:0], fields_i.rs1,
                          fields_i.funct3, fields_i.rd, OP_IALU};
            (fields_i.cls == CLS_LOAD):
                word_o = {imm[11:0], fields_i.rs1,
                          fields_i.funct3, fields_i.rd, OP_LOAD};
            (fields_i.cls == CLS_STORE):
                word_o = {imm[11:5], fields_i.rs2, fields_i.rs1,
                          fields_i.funct3, imm[4:0], OP_STORE};
            // Branch offset is even; imm[0] is never encoded.
            (fields_i.cls == CLS_BRANCH):
                word_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1,
                          fields_i.funct3, imm[4:1], imm[11], OP_BRANCH};
            default:
                legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/instr_load_encoder.sv
// Program loader: encodes field bundles and writes them to consecutive imem words.
// Ports: clk, rst (sync, active high), bus (slave side of instr_load_encoder_if).
module instr_load_encoder
    import instr_load_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_load_encoder_if.slave    bus
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;
    logic [31:0]           word_q, word_d;

    instr_fields_t fields;
    logic [31:0]   pk_word;
    logic          pk_legal;

    assign fields = '{
        cls:    bus.in_class,
        rd:     bus.in_rd,
        rs1:    bus.in_rs1,
        rs2:    bus.in_rs2,
        funct3: bus.in_funct3,
        funct7: bus.in_funct7,
        imm:    bus.in_imm
    };

    rv_instr_pack u_pack (
        .fields_i (fields),
        .word_o   (pk_word),
        .legal_o  (pk_legal)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        last_d  = last_q;
        word_d  = word_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.start_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (bus.in_valid) begin
                    if (pk_legal) begin
                        word_d  = pk_word;
                        last_d  = bus.in_last;
                        state_d = ST_WRITE;
                    end else begin
                        err_d = 1'b1;
                        if (bus.in_last) state_d = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + 1'b1;
                if (count_q != '1) count_d = count_q + 1'b1;
                state_d = last_q ? ST_DONE : ST_ACCEPT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            last_q  <= last_d;
            word_q  <= word_d;
        end
    end

    // Qualify with rst so a reset landing on a WRITE cycle issues no write.
    assign bus.in_ready  = (state_q == ST_ACCEPT) && !rst;
    assign bus.mem_we    = (state_q == ST_WRITE) && !rst;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = word_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = err_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_instr_load_encoder.sv
// Directed bench for instr_load_encoder with a field-level encoding model.
// Writes are predicted into a queue and checked by one negedge compare process.
module tb_instr_load_encoder;
    import instr_load_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_load_encoder_if #(.ADDR_WIDTH(8)) bus ();

    instr_load_encoder #(.ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        expq[$];
    wr_t        cmp_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_addr   = '0;
    logic [8:0] m_count  = '0;
    logic       m_err    = 1'b0;
    bit         poke_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Field-level RV32I packing, by shifts of each field to its bit position.
    function automatic logic [32:0] model_enc(
        input int unsigned cls, rd, rs1, rs2, f3, f7, imm);
        int unsigned w;
        logic        legal;
        legal = 1'b1;
        w = 0;
        case (cls)
            0: w = 32'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15)
                   | (rs2 << 20) | (f7 << 25);
            1: w = 32'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15)
                   | ((imm & 32'hFFF) << 20);
            2: w = 32'h03 | (rd << 7) | (f3 << 12) | (rs1 << 15)
                   | ((imm & 32'hFFF) << 20);
            3: w = 32'h23 | ((imm & 32'h1F) << 7) | (f3 << 12)
                   | (rs1 << 15) | (rs2 << 20)
                   | (((imm >> 5) & 32'h7F) << 25);
            4: w = 32'h63 | (((imm >> 11) & 1) << 7)
                   | (((imm >> 1) & 32'hF) << 8) | (f3 << 12)
                   | (rs1 << 15) | (rs2 << 20)
                   | (((imm >> 5) & 32'h3F) << 25)
                   | (((imm >> 12) & 1) << 31);
            default: legal = 1'b0;
        endcase
        return {legal, w};
    endfunction

    always @(negedge clk) begin
        if (bus.mem_we) begin
            check("ready_in_write", {31'b0, bus.in_ready}, 32'd0);
            if (expq.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                cmp_e = expq.pop_front();
                check("wr_addr", {24'b0, bus.mem_addr}, {24'b0, cmp_e.a});
                check("wr_data", bus.mem_wdata, cmp_e.d);
            end
        end
    end

    task automatic do_start(input logic [7:0] a);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_addr = a;
        @(negedge clk);
        bus.start = 1'b0;
        m_addr  = a;
        m_count = '0;
        m_err   = 1'b0;
        check("busy_after_start", {31'b0, bus.busy}, 32'd1);
        check("count_cleared", {23'b0, bus.count}, 32'd0);
        check("err_cleared", {31'b0, bus.err}, 32'd0);
    endtask

    // Present one bundle and return just after the accepting edge.
    task automatic send(input logic [2:0] cls, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [12:0] imm, input logic last,
                        input int pre_stall);
        logic [32:0] m;
        int          t;
        repeat (pre_stall) @(negedge clk);
        @(negedge clk);
        bus.in_class  = cls;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            bus.start      = poke_start && ($urandom_range(0, 1) == 1);
            bus.start_addr = 8'h55;
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check("accept_timeout", 32'd1, 32'd0);
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        m = model_enc(cls, rd, rs1, rs2, f3, f7, imm);
        if (m[32]) begin
            expq.push_back('{m_addr, m[31:0]});
            m_addr = m_addr + 8'd1;
            if (m_count != 9'h1FF) m_count = m_count + 9'd1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic post(input logic last, input logic legal);
        @(negedge clk);
        if (legal) begin
            check("we_after_accept", {31'b0, bus.mem_we}, 32'd1);
            if (last) @(negedge clk);
        end else if (!last) begin
            check("illegal_no_we", {30'b0, bus.mem_we, bus.in_ready}, 32'd1);
        end
        if (last) begin
            check("done_pulse", {31'b0, bus.done}, 32'd1);
            check("done_busy", {31'b0, bus.busy}, 32'd1);
            check("count", {23'b0, bus.count}, {23'b0, m_count});
            check("err", {31'b0, bus.err}, {31'b0, m_err});
            @(negedge clk);
            check("idle_after_done", {30'b0, bus.busy, bus.done}, 32'd0);
        end
    endtask

    task automatic item(input logic [2:0] cls, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [12:0] imm, input logic last,
                        input int pre_stall);
        send(cls, rd, rs1, rs2, f3, f7, imm, last, pre_stall);
        post(last, cls < 3'd5);
    endtask

    logic [32:0] lit;

    initial begin
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.in_valid   = 1'b0;
        bus.in_class   = '0;
        bus.in_last    = 1'b0;
        bus.in_rd      = '0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_funct3  = '0;
        bus.in_funct7  = '0;
        bus.in_imm     = '0;

        repeat (2) @(negedge clk);
        check("rst_flags", {27'b0, bus.in_ready, bus.mem_we, bus.busy,
                            bus.done, bus.err}, 32'd0);
        check("rst_addr", {24'b0, bus.mem_addr}, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_count", {23'b0, bus.count}, 32'd0);
        rst = 1'b0;

        lit = model_enc(0, 3, 1, 2, 0, 0, 0);
        check("lit_add", lit[31:0], 32'h002081B3);
        lit = model_enc(1, 1, 0, 0, 0, 0, 5);
        check("lit_addi", lit[31:0], 32'h00500093);
        lit = model_enc(2, 5, 2, 0, 2, 0, 8);
        check("lit_lw", lit[31:0], 32'h00812283);
        lit = model_enc(3, 0, 2, 6, 2, 0, 12);
        check("lit_sw", lit[31:0], 32'h00612623);
        lit = model_enc(4, 0, 1, 2, 0, 0, 13'h1FFC);
        check("lit_beq", lit[31:0], 32'hFE208EE3);

        // R-type single word
        do_start(8'h10);
        item(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 0);

        // Burst of four, back to back
        do_start(8'h00);
        item(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 1'b0, 0);
        item(3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8, 1'b0, 0);
        item(3'd3, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0, 13'd12, 1'b0, 0);
        item(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC, 1'b1, 0);

        // Address wrap
        do_start(8'hFF);
        item(3'd0, 5'd7, 5'd8, 5'd9, 3'd4, 7'h20, 13'd0, 1'b0, 0);
        item(3'd1, 5'd10, 5'd11, 5'd0, 3'd7, 7'h7F, 13'h0800, 1'b1, 1);

        // Illegal classes: mid-session, then as the last bundle
        do_start(8'h20);
        item(3'd2, 5'd4, 5'd3, 5'd0, 3'd0, 7'd0, 13'h0FFF, 1'b0, 0);
        item(3'd6, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 13'd1, 1'b0, 0);
        item(3'd3, 5'd31, 5'd30, 5'd29, 3'd1, 7'h55, 13'h0FE0, 1'b0, 0);
        item(3'd6, 5'd2, 5'd2, 5'd2, 3'd2, 7'd2, 13'd2, 1'b1, 0);

        // Random stalls with start poked while busy
        poke_start = 1'b1;
        do_start(8'h80);
        for (int i = 0; i < 8; i++) begin
            item(3'($urandom_range(0, 4)), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), 13'($urandom),
                 (i == 7), $urandom_range(0, 3));
        end
        poke_start = 1'b0;

        // Reset in the cycle after an accept
        do_start(8'h40);
        send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 13'd0, 1'b0, 0);
        rst = 1'b1;
        expq.delete();
        @(negedge clk);
        check("rst_cycle_no_we", {31'b0, bus.mem_we}, 32'd0);
        @(negedge clk);
        check("rst_mid_flags", {27'b0, bus.in_ready, bus.mem_we, bus.busy,
                                bus.done, bus.err}, 32'd0);
        check("rst_mid_addr", {24'b0, bus.mem_addr}, 32'd0);
        check("rst_mid_wdata", bus.mem_wdata, 32'd0);
        check("rst_mid_count", {23'b0, bus.count}, 32'd0);
        rst = 1'b0;
        do_start(8'h08);
        item(3'd4, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 13'h0010, 1'b1, 0);

        repeat (2) @(negedge clk);
        check("queue_drained", expq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
